// File: rtl/and_gate_pkg.sv
// ============================================================================
// Module  : and_gate_pkg
// Purpose : Shared defaults and types for the and_gate leaf cell.
// Contents: AND_GATE_WIDTH_DEF - default number of AND lanes
//           AND_GATE_CNT_W_DEF - default width of the all-ones sample counter
//           cov_t              - 2-input truth-table coverage vector
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package and_gate_pkg;

  localparam int AND_GATE_WIDTH_DEF = 1;
  localparam int AND_GATE_CNT_W_DEF = 16;

  // One bit per lane-0 input combination, indexed by {a[0], b[0]}.
  typedef logic [3:0] cov_t;

endpackage : and_gate_pkg

`default_nettype wire

// File: rtl/and_gate_sat_cnt.sv
// ============================================================================
// Module  : and_gate_sat_cnt
// Purpose : Saturating up-counter with synchronous clear.
// Ports   : clk   - clock, rising edge
//           rst_n - synchronous active-low reset
//           inc   - count request for this edge
//           clear - synchronous clear, wins over inc
//           cnt   - current count, sticks at all ones
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module and_gate_sat_cnt
  import and_gate_pkg::*;
#(
  parameter int W = AND_GATE_CNT_W_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         clear,
  output logic [W-1:0] cnt
);

  localparam logic [W-1:0] CNT_MAX = {W{1'b1}};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (inc && (cnt != CNT_MAX)) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule : and_gate_sat_cnt

`default_nettype wire

// File: rtl/and_gate.sv
// ============================================================================
// Module  : and_gate
// Purpose : Bitwise two-input AND with a combinational result, a registered
//           valid-qualified copy, an AND-reduction flag and a saturating
//           count of accepted all-ones samples.
// Ports   : clk, rst_n (sync, active low)
//           a, b       - operands, WIDTH bits
//           in_valid   - qualifies a/b for the registered path and statistics
//           clear      - synchronous clear of ones_cnt and coverage
//           c          - a & b, combinational
//           c_q        - a & b registered on valid samples
//           out_valid  - in_valid delayed one cycle
//           all_high   - &c_q
//           ones_cnt   - accepted samples whose a & b was all ones
//           cov        - lane-0 truth-table coverage (sticky)
//           cov_full   - &cov
// Config  : AND_GATE_TRUTH_COV_EN enables cov/cov_full; otherwise both read 0.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module and_gate
  import and_gate_pkg::*;
#(
  parameter int WIDTH = AND_GATE_WIDTH_DEF,
  parameter int CNT_W = AND_GATE_CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             in_valid,
  input  logic             clear,
  output logic [WIDTH-1:0] c,
  output logic [WIDTH-1:0] c_q,
  output logic             out_valid,
  output logic             all_high,
  output logic [CNT_W-1:0] ones_cnt,
  output cov_t             cov,
  output logic             cov_full
);

  logic ones_hit;

  assign c        = a & b;
  assign all_high = &c_q;
  assign ones_hit = in_valid && (&c);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      c_q       <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        c_q <= c;
      end
    end
  end

  and_gate_sat_cnt #(
    .W (CNT_W)
  ) u_ones_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (ones_hit),
    .clear (clear),
    .cnt   (ones_cnt)
  );

`ifdef AND_GATE_TRUTH_COV_EN
  cov_t cov_q;

  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      cov_q <= '0;
    end else if (in_valid) begin
      // Explicit decode keeps an X operand from corrupting the whole vector.
      case ({a[0], b[0]})
        2'b00:   cov_q[0] <= 1'b1;
        2'b01:   cov_q[1] <= 1'b1;
        2'b10:   cov_q[2] <= 1'b1;
        2'b11:   cov_q[3] <= 1'b1;
        default: cov_q <= cov_q;
      endcase
    end
  end

  assign cov      = cov_q;
  assign cov_full = &cov_q;
`else
  assign cov      = '0;
  assign cov_full = 1'b0;
`endif

endmodule : and_gate

`default_nettype wire

// File: tb/tb_and_gate.sv
// ============================================================================
// Module  : tb_and_gate
// Purpose : Directed self-checking bench for and_gate. Three instances:
//           u1 (WIDTH=1, CNT_W=16), u2 (WIDTH=1, CNT_W=2), u8 (WIDTH=8).
// Config  : honours AND_GATE_TRUTH_COV_EN for the coverage expectations.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_and_gate;
  import and_gate_pkg::*;

  logic clk = 1'b0;
  logic rst_n, clear;
  always #5 clk = ~clk;

  // u1
  logic        a1, b1, v1;
  logic        c1, cq1, ov1, ah1, cf1;
  logic [15:0] cnt1;
  cov_t        cov1;
  // u2
  logic        a2, b2, v2;
  logic        c2, cq2, ov2, ah2, cf2;
  logic [1:0]  cnt2;
  cov_t        cov2;
  // u8
  logic [7:0]  a8, b8, c8, cq8;
  logic        v8, ov8, ah8, cf8;
  logic [15:0] cnt8;
  cov_t        cov8;

  int passed = 0;
  int total  = 0;

`ifdef AND_GATE_TRUTH_COV_EN
  localparam logic [3:0] COV_ALL  = 4'hF;
  localparam logic       FULL_EXP = 1'b1;
`else
  localparam logic [3:0] COV_ALL  = 4'h0;
  localparam logic       FULL_EXP = 1'b0;
`endif

  and_gate #(.WIDTH(1), .CNT_W(16)) u1 (
    .clk(clk), .rst_n(rst_n), .a(a1), .b(b1), .in_valid(v1), .clear(clear),
    .c(c1), .c_q(cq1), .out_valid(ov1), .all_high(ah1), .ones_cnt(cnt1),
    .cov(cov1), .cov_full(cf1));

  and_gate #(.WIDTH(1), .CNT_W(2)) u2 (
    .clk(clk), .rst_n(rst_n), .a(a2), .b(b2), .in_valid(v2), .clear(clear),
    .c(c2), .c_q(cq2), .out_valid(ov2), .all_high(ah2), .ones_cnt(cnt2),
    .cov(cov2), .cov_full(cf2));

  and_gate #(.WIDTH(8), .CNT_W(16)) u8 (
    .clk(clk), .rst_n(rst_n), .a(a8), .b(b8), .in_valid(v8), .clear(clear),
    .c(c8), .c_q(cq8), .out_valid(ov8), .all_high(ah8), .ones_cnt(cnt8),
    .cov(cov8), .cov_full(cf8));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; clear = 1'b0;
    a1 = 0; b1 = 0; v1 = 0;
    a2 = 0; b2 = 0; v2 = 0;
    a8 = '0; b8 = '0; v8 = 0;

    // Reset state
    tick(); tick();
    chk("rst_cq",   32'(cq1),  0);
    chk("rst_ov",   32'(ov1),  0);
    chk("rst_ah",   32'(ah1),  0);
    chk("rst_cnt",  32'(cnt1), 0);
    chk("rst_cov",  32'(cov1), 0);
    chk("rst_cq8",  32'(cq8),  0);
    rst_n = 1'b1;

    // Truth table, WIDTH=1
    v1 = 1;
    for (int i = 0; i < 4; i++) begin
      a1 = i[1]; b1 = i[0];
      #1;
      chk($sformatf("tt_c_%0d", i), 32'(c1), 32'(i == 3));
      tick();
      chk($sformatf("tt_cq_%0d", i), 32'(cq1), 32'(i == 3));
      chk($sformatf("tt_ov_%0d", i), 32'(ov1), 1);
      chk($sformatf("tt_ah_%0d", i), 32'(ah1), 32'(i == 3));
    end
    chk("tt_cnt",  32'(cnt1), 1);
    chk("tt_cov",  32'(cov1), 32'(COV_ALL));
    chk("tt_full", 32'(cf1),  32'(FULL_EXP));

    // Reset held two edges while a valid 11 sample is presented
    a1 = 1; b1 = 1; v1 = 1; rst_n = 1'b0;
    tick();
    chk("rh_c",   32'(c1),   1);
    tick();
    chk("rh_cq",  32'(cq1),  0);
    chk("rh_ov",  32'(ov1),  0);
    chk("rh_cnt", 32'(cnt1), 0);
    chk("rh_cov", 32'(cov1), 0);
    rst_n = 1'b1;
    tick();
    chk("rr_cq",  32'(cq1),  1);
    chk("rr_cnt", 32'(cnt1), 1);

    // clear zeroes the counter but leaves c_q and out_valid alone
    v1 = 0; clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("clr_cnt", 32'(cnt1), 0);
    chk("clr_cq",  32'(cq1),  1);
    chk("clr_ov",  32'(ov1),  0);

    // Four valid 11 samples, then one 10 sample
    v1 = 1;
    repeat (4) tick();
    chk("c4_cnt", 32'(cnt1), 4);
    b1 = 0;
    tick();
    chk("c4_cnt10", 32'(cnt1), 4);
    chk("c4_cq10",  32'(cq1),  0);
    chk("c4_ah10",  32'(ah1),  0);

    // clear beats a simultaneous increment
    b1 = 1; clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("clrpri_cnt", 32'(cnt1), 0);
    chk("clrpri_cq",  32'(cq1),  1);
    v1 = 0;

    // Saturation at CNT_W=2
    a2 = 1; b2 = 1; v2 = 1;
    for (int i = 1; i <= 6; i++) begin
      tick();
      chk($sformatf("sat_%0d", i), 32'(cnt2), (i < 3) ? i : 3);
    end
    chk("sat_ah", 32'(ah2), 1);
    v2 = 0;

    // WIDTH=8: load a value, then show c_q holds on an invalid sample
    a8 = 8'hFF; b8 = 8'h0F; v8 = 1;
    tick();
    chk("w8_cq_load", 32'(cq8), 32'h0F);
    chk("w8_ah_load", 32'(ah8), 0);
    a8 = 8'hF0; b8 = 8'h3C; v8 = 0;
    #1;
    chk("w8_c", 32'(c8), 32'h30);
    tick();
    chk("w8_cq_hold", 32'(cq8), 32'h0F);
    chk("w8_ov",      32'(ov8), 0);
    chk("w8_cnt0",    32'(cnt8), 0);
    a8 = 8'hFF; b8 = 8'hFF; v8 = 1;
    tick();
    chk("w8_ah",  32'(ah8),  1);
    chk("w8_cnt", 32'(cnt8), 1);
    chk("w8_cq",  32'(cq8),  32'hFF);
    v8 = 0;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule : tb_and_gate

`default_nettype wire
